// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin write arbiter: grants one producer at a time for a burst of up to
// BURST_LEN words and forwards them, tagged with the source index, to a sync FIFO.
module fifo_wr_rr_arbiter #(
    parameter int  NUM_PORTS  = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  BURST_LEN  = 4,
    localparam int ID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                           i_clk,
    input  logic                           i_s_rst,
    input  logic [NUM_PORTS-1:0]           i_req_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_PORTS-1:0]           o_req_ready,
    output logic                           o_fifo_wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] o_fifo_wr_data,
    input  logic                           i_fifo_full,
    output logic [ID_WIDTH-1:0]            o_grant_id,
    output logic                           o_busy
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              r_state;
    logic [ID_WIDTH-1:0] r_grant_id;
    logic [ID_WIDTH-1:0] r_last_grant;
    logic [CNT_W-1:0]    r_beat_cnt;

    logic [DATA_WIDTH-1:0] w_port_data [NUM_PORTS];
    logic                  w_busy;
    logic                  w_sel_valid;
    logic                  w_xfer;
    logic                  w_any_valid;
    logic [ID_WIDTH-1:0]   w_winner;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign w_port_data[gi] = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign o_req_ready[gi] = w_busy && (r_grant_id == ID_WIDTH'(gi)) && !i_fifo_full;
        end
    endgenerate

    assign w_busy      = (r_state == S_BURST);
    assign w_sel_valid = i_req_valid[r_grant_id];
    assign w_xfer      = w_busy && w_sel_valid && !i_fifo_full;
    assign w_any_valid = |i_req_valid;

    // Rotating priority: the port just after the previous winner is searched first.
    always_comb begin
        logic found;
        int   idx;
        w_winner = '0;
        found    = 1'b0;
        idx      = 0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            idx = (int'(r_last_grant) + off) % NUM_PORTS;
            if (!found && i_req_valid[idx]) begin
                w_winner = ID_WIDTH'(idx);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            r_state      <= S_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= ID_WIDTH'(NUM_PORTS - 1);
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_beat_cnt   <= '0;
                        r_state      <= S_BURST;
                    end
                end
                S_BURST: begin
                    // A full FIFO freezes the burst; otherwise a missing word forfeits the grant.
                    if (!i_fifo_full) begin
                        if (!w_sel_valid) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                            if (r_beat_cnt == CNT_W'(BURST_LEN - 1)) begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_fifo_wr_en   = w_xfer;
    assign o_fifo_wr_data = w_xfer ? {r_grant_id, w_port_data[r_grant_id]} : '0;
    assign o_grant_id     = r_grant_id;
    assign o_busy         = w_busy;

    a_no_write_when_full: assert property (@(posedge i_clk) disable iff (i_s_rst)
        !(o_fifo_wr_en && i_fifo_full));

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Bench for fifo_wr_rr_arbiter: per-cycle reference model, directed scenarios with
// literal expectations, and a random phase with a per-port ordering scoreboard.
module tb_fifo_wr_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              srst;
    logic [N-1:0]      valid;
    logic [N*DW-1:0]   data;
    logic              full;
    logic [N-1:0]      ready;
    logic              wr_en;
    logic [IW+DW-1:0]  wr_data;
    logic [IW-1:0]     gid;
    logic              busy;

    fifo_wr_rr_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .i_clk(clk), .i_s_rst(srst), .i_req_valid(valid), .i_req_data(data),
        .o_req_ready(ready), .o_fifo_wr_en(wr_en), .o_fifo_wr_data(wr_data),
        .i_fifo_full(full), .o_grant_id(gid), .o_busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // producers: each port offers rem[k] more words, payload seq[k] increments per accept
    int          rem [N];
    logic [DW-1:0] seq [N];
    logic [N-1:0] drop;
    logic        full_v, rst_v, rst_once;

    // observation logs
    logic [IW+DW-1:0] wlog[$];
    int               glog[$];
    int               stalls;
    bit               prev_busy;
    bit               sb_on;
    logic [DW-1:0]    sb_next [N];

    // reference model
    bit  m_on = 0, m_busy;
    int  m_g, m_last, m_words;
    logic [N-1:0]     e_ready;
    logic             e_wr;
    logic [IW+DW-1:0] e_data;
    bit               ok, found;
    int               p;

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_last = N - 1; m_words = 0;
    endtask

    always @(negedge clk) begin
        if (!m_on) begin
            if (srst === 1'b1) begin
                model_reset();
                m_on = 1;
            end
        end else begin
            e_ready = '0;
            e_wr    = 1'b0;
            e_data  = '0;
            if (m_busy) begin
                if (!full) e_ready[m_g] = 1'b1;
                e_wr = valid[m_g] && !full;
                if (e_wr) e_data = {m_g[IW-1:0], data[m_g*DW +: DW]};
            end
            ok = (ready === e_ready) && (wr_en === e_wr) && (wr_data === e_data) &&
                 (busy === m_busy) && (!m_busy || gid === m_g[IW-1:0]);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL model t=%0t ready=%b/%b wr_en=%b/%b data=%h/%h busy=%b/%b gid=%0d/%0d (got/required)",
                         $time, ready, e_ready, wr_en, e_wr, wr_data, e_data, busy, m_busy, gid, m_g);
            end

            if (wr_en === 1'b1) wlog.push_back(wr_data);
            if (busy === 1'b1 && !prev_busy) glog.push_back(int'(gid));
            if (busy === 1'b1 && full === 1'b1) stalls++;
            prev_busy = (busy === 1'b1);

            if (sb_on && wr_en === 1'b1) begin
                n_vec++;
                if (wr_data[DW-1:0] !== sb_next[wr_data[IW+DW-1:DW]]) begin
                    n_err++;
                    $display("FAIL order port=%0d got %h required %h", wr_data[IW+DW-1:DW],
                             wr_data[DW-1:0], sb_next[wr_data[IW+DW-1:DW]]);
                end
                sb_next[wr_data[IW+DW-1:DW]] = wr_data[DW-1:0] + 1'b1;
            end

            // advance the model with the inputs that the coming edge will sample
            if (srst) begin
                model_reset();
            end else if (!m_busy) begin
                if (valid != '0) begin
                    found = 0;
                    for (int k = 1; k <= N; k++) begin
                        p = (m_last + k) % N;
                        if (!found && valid[p]) begin
                            m_g = p;
                            found = 1;
                        end
                    end
                    m_last = m_g; m_busy = 1; m_words = 0;
                end
            end else if (!full) begin
                if (!valid[m_g]) m_busy = 0;
                else begin
                    m_words++;
                    if (m_words == BL) m_busy = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            valid[k] = (rem[k] > 0) && !drop[k];
            data[k*DW +: DW] = seq[k];
        end
        full = full_v;
        srst = rst_v;
    endtask

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = ready & valid;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k] === 1'b1) begin
                rem[k]--;
                seq[k] = seq[k] + 1'b1;
            end
        end
        if (rst_once) begin
            rst_v = 0;
            rst_once = 0;
        end
        drive();
    endtask

    task automatic do_reset();
        rst_v = 1; full_v = 0; drop = '0; rst_once = 0;
        for (int k = 0; k < N; k++) begin
            rem[k] = 0;
            seq[k] = '0;
        end
        drive();
        step();
        step();
        rst_v = 0;
        drive();
        wlog.delete(); glog.delete(); stalls = 0;
    endtask

    logic [IW+DW-1:0] exp1 [4] = '{10'h011, 10'h012, 10'h013, 10'h014};
    int               exp2 [5] = '{0, 1, 2, 3, 0};
    int               zero_seen;
    bit               refilled, full_done;

    initial begin
        sb_on = 0; prev_busy = 0;
        do_reset();
        chk("reset_busy", busy, 0);
        chk("reset_ready", ready, 0);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_gid", gid, 0);

        // 1: single producer, one full burst
        seq[0] = 8'h11; rem[0] = 4; drive();
        repeat (10) step();
        chk("t1_count", wlog.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_word", wlog[i], exp1[i]);
        chk("t1_idle", busy, 0);

        // 2: all ports requesting, strict rotation with bubble
        do_reset();
        for (int k = 0; k < N; k++) begin
            rem[k] = 8;
            seq[k] = 8'(k * 16);
        end
        drive();
        repeat (27) step();
        chk("t2_grants", glog.size() >= 5, 1);
        for (int i = 0; i < 5; i++) chk("t2_order", glog[i], exp2[i]);
        for (int i = 0; i < 16; i++) chk("t2_word_id", wlog[i][IW+DW-1:DW], i / 4);

        // 3: FIFO full stall mid-burst
        do_reset();
        seq[2] = 8'h20; rem[2] = 4; drive();
        full_done = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (!full_done && wlog.size() == 2) begin
                full_v = 1; drive();
                step(); step();
                full_v = 0;
                step();
                full_done = 1;
            end
        end
        chk("t3_count", wlog.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_word", wlog[i], 10'h220 + i);
        chk("t3_stalls", stalls, 3);

        // 4: port 1 drops valid after 2 words; port 2 wins next
        do_reset();
        seq[1] = 8'h40; rem[1] = 2;
        seq[2] = 8'h50; rem[2] = 4;
        drive();
        zero_seen = 0; refilled = 0;
        repeat (16) begin
            step();
            if (!refilled && rem[1] == 0) begin
                zero_seen++;
                if (zero_seen == 2) begin
                    rem[1] = 2; refilled = 1; drive();
                end
            end
        end
        chk("t4_grant0", glog[0], 1);
        chk("t4_grant1", glog[1], 2);
        chk("t4_grant2", glog[2], 1);
        chk("t4_word0", wlog[0], 10'h140);
        chk("t4_word1", wlog[1], 10'h141);
        chk("t4_word2", wlog[2], 10'h250);

        // 5: reset pulsed mid-burst
        do_reset();
        seq[3] = 8'h60; rem[3] = 4; drive();
        for (int c = 0; c < 10 && wlog.size() < 1; c++) step();
        chk("t5_first_word", wlog.size(), 1);
        rst_v = 1; rst_once = 1; drive();
        step();
        chk("t5_busy", busy, 0);
        chk("t5_ready", ready, 0);
        chk("t5_wr_en", wr_en, 0);
        chk("t5_wr_data", wr_data, 0);
        chk("t5_gid", gid, 0);
        glog.delete();
        seq[0] = 8'h70; rem[0] = 2; drive();
        repeat (8) step();
        chk("t5_grant_after_reset", glog[0], 0);

        // 6: random traffic
        do_reset();
        for (int k = 0; k < N; k++) sb_next[k] = seq[k];
        sb_on = 1;
        repeat (3000) begin
            for (int k = 0; k < N; k++) begin
                if (rem[k] == 0 && $urandom_range(0, 3) == 0) rem[k] = $urandom_range(1, 6);
                drop[k] = ($urandom_range(0, 7) == 0);
            end
            full_v = ($urandom_range(0, 3) == 0);
            drive();
            step();
        end
        sb_on = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
